layer_sequencer: RTL
====================

# layer_sequencer

Serialises the parallel result vector of one fully-connected neuron layer into the one-word-per-cycle input stream consumed by the next layer. It captures all `NN` neuron outputs when the layer signals completion, then replays them in index order with a valid/ready handshake. It raises a completion pulse and sticky error flags. One instance sits between each pair of consecutive layers in the inference pipeline.

## Interface
- `NN`, 30, number of neurons in the producing layer (≥2)
- `dataWidth`, 16, bits per neuron output word
- `CLK`  in  1  rising-edge clock
- `RESET`  in  1  asynchronous, active-low reset
- `l_valid`  in  NN  per-neuron output-valid from producing layer
- `l_data`  in  NN*dataWidth  neuron outputs; word i at `[i*dataWidth +: dataWidth]`
- `x_out`  out  dataWidth  serialised word to next layer
- `x_valid`  out  1  `x_out` holds a valid word
- `x_ready`  in  1  consumer accepts the word; tie high for neuron layers
- `busy`  out  1  high while in STREAM
- `done`  out  1  one-cycle pulse after the last word transfers
- `err_partial`  out  1  sticky; a capture occurred with some but not all `l_valid` bits set
- `overrun`  out  1  sticky; `l_valid` activity arrived while busy and was dropped

## Operation
- States: IDLE, STREAM.
- IDLE: when `|l_valid` is high, load all NN words of `l_data` into the buffer, set count=0, and go to STREAM.
  - If the capture has `&l_valid` low, set `err_partial`. The capture still proceeds.
- STREAM: `x_valid`=1 and `x_out`=buffer word[count].
  - A beat transfers when `x_valid && x_ready`.
  - On a transfer with count<NN-1: count increments.
  - On a transfer with count=NN-1: go to IDLE and pulse `done` next cycle.
  - With `x_ready` low: `x_out` and count hold unchanged.
- `|l_valid` in STREAM, including the final-beat cycle: the data is ignored, `overrun` is set, and streaming continues unaffected.
- count width is `$clog2(NN)`. It never wraps past NN-1.
- Words pass through unmodified (no sign or width change).
- RESET low, at any time including mid-stream: immediately go to IDLE, count=0, and drive every output to 0. The buffer contents need not be cleared. The partial stream is abandoned and `done` does not pulse.

## Timing
- Reset values: `x_out`=0, `x_valid`=0, `busy`=0, `done`=0, `err_partial`=0, `overrun`=0.
- Capture at edge t (`l_valid` high in cycle t-1): `x_valid` and `busy` are high from cycle t, with word 0.
- With `x_ready` held high, word i appears in cycle t+i. The last word appears in cycle t+NN-1.
- `done`=1 in cycle t+NN. In that same cycle `busy`=0 and `x_valid`=0.
- A new capture is accepted in the `done` cycle. Back-to-back layers therefore have a minimum period of NN+1 cycles.
- All outputs are registered, so there is no combinational path from `l_valid`/`x_ready` to `x_valid`.
- `x_out` is a don't-care when `x_valid`=0, but is driven 0 after reset.

## Structure
- Shared package: state enum (IDLE, STREAM). Per-instance widths derive from parameters; there are no other package constants.
- Buffer: use an NN-entry register array indexed by count, or a shift register shifting on each transfer. Either is acceptable if timing holds.
- No sub-module; this is a single flat module.

## Test plan
- NN=4, dataWidth=16, `l_data`={0x0004,0x0003,0x0002,0x0001} (word0=0x0001), `l_valid`=4'hF for one cycle, `x_ready`=1 → `x_out` reads 1,2,3,4 on four consecutive cycles, `done` pulses on cycle 5, and the flags stay 0.
- Same stimulus with `x_ready` low for 3 cycles during word 1 → word 1 held stable for 4 cycles, no word skipped or duplicated, `done` delayed by 3 cycles.
- `l_valid`=4'b0111 capture → the stream proceeds normally with all 4 words and `err_partial`=1 until reset.
- Second `l_valid`=4'hF pulse during word 2 → the first stream completes with its original data and `overrun`=1. A pulse in the `done` cycle starts a fresh stream without setting `overrun`.
- RESET asserted asynchronously (mid-cycle) during word 1 → all outputs are 0 immediately, with no `done`. After release, a new capture streams correctly from word 0.
- NN=30 default: 30 sequential words match a 30-entry random vector, and `busy` is high for exactly 30 cycles.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer.
// Holds the two-state controller encoding. Widths are per-instance and derive
// from the module parameters, so nothing else lives here.
package layer_sequencer_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } seq_state_e;

endpackage : layer_sequencer_pkg

// File: rtl/layer_sequencer.sv
// layer_sequencer: captures the NN parallel outputs of a fully-connected layer
// and replays them one word per cycle, in index order, to the next layer over
// a valid/ready handshake.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous active-low reset
//   l_valid      per-neuron output-valid from the producing layer (NN bits)
//   l_data       neuron outputs, word i at [i*dataWidth +: dataWidth]
//   x_out        serialised word to the next layer
//   x_valid      x_out holds a valid word
//   x_ready      consumer accepts the current word
//   busy         high while streaming
//   done         one-cycle pulse after the last word transfers
//   err_partial  sticky: a capture saw some but not all l_valid bits
//   overrun      sticky: l_valid activity arrived while busy and was dropped
module layer_sequencer
   import layer_sequencer_pkg::*;
#(
   parameter int unsigned NN        = 30,
   parameter int unsigned dataWidth = 16
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NN-1:0]             l_valid,
   input  logic [NN*dataWidth-1:0]   l_data,
   output logic [dataWidth-1:0]      x_out,
   output logic                      x_valid,
   input  logic                      x_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      err_partial,
   output logic                      overrun
);

   localparam int unsigned   CW        = $clog2(NN);
   localparam logic [CW-1:0] LAST      = CW'(NN - 1);
   localparam logic [0:0]    ST_IDLE   = 1'(IDLE);
   localparam logic [0:0]    ST_STREAM = 1'(STREAM);

   logic [0:0]           state;
   logic [0:0]           state_nx;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_nx;
   logic [dataWidth-1:0] x_out_nx;
   logic                 done_nx;
   logic                 err_partial_nx;
   logic                 overrun_nx;
   logic                 load_c;
   logic                 any_valid_c;
   logic                 all_valid_c;

   logic [dataWidth-1:0] buffer [NN];

   assign any_valid_c = |l_valid;
   assign all_valid_c = &l_valid;

   // Next-state and next-output logic; x_out is pre-loaded with the word that
   // will be current after the edge so the output stays a plain flop.
   always_comb begin
      state_nx       = state;
      count_nx       = count;
      x_out_nx       = x_out;
      done_nx        = 1'b0;
      err_partial_nx = err_partial;
      overrun_nx     = overrun;
      load_c         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (any_valid_c) begin
               load_c   = 1'b1;
               state_nx = ST_STREAM;
               count_nx = '0;
               x_out_nx = l_data[0 +: dataWidth];
               if (!all_valid_c) begin
                  err_partial_nx = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            // Any producer activity while streaming is dropped and flagged.
            if (any_valid_c) begin
               overrun_nx = 1'b1;
            end
            // x_valid is always high in this state, so ready alone transfers.
            if (x_ready) begin
               if (count == LAST) begin
                  state_nx = ST_IDLE;
                  count_nx = '0;
                  done_nx  = 1'b1;
               end else begin
                  count_nx = count + CW'(1);
                  x_out_nx = buffer[count + CW'(1)];
               end
            end
         end

         default: begin
            state_nx = ST_IDLE;
            count_nx = '0;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= ST_IDLE;
         count       <= '0;
         x_out       <= '0;
         x_valid     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_partial <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nx;
         count       <= count_nx;
         x_out       <= x_out_nx;
         x_valid     <= (state_nx == ST_STREAM);
         busy        <= (state_nx == ST_STREAM);
         done        <= done_nx;
         err_partial <= err_partial_nx;
         overrun     <= overrun_nx;
      end
   end

   // Capture buffer; contents are don't-care until the next load.
   always_ff @(posedge CLK) begin
      if (load_c) begin
         for (int i = 0; i < int'(NN); i++) begin
            buffer[i] <= l_data[i*dataWidth +: dataWidth];
         end
      end
   end

endmodule : layer_sequencer
